// File: rtl/occ_lookup.sv
// BWT occurrence lookup: fetches the checkpointed BWT word(s) for positions k and k+s and
// returns per-symbol occurrence counts for both, reading memory once when both share a word.
module occ_lookup #(
  parameter int unsigned KLS_W  = 32,
  parameter int unsigned MEM_AW = 26,
  parameter int unsigned MEM_W  = 128 + 4 * KLS_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KLS_W-1:0]  occ_k_i,
  input  logic [KLS_W-1:0]  occ_ks_i,
  input  logic              occ_lookup_i,
  output logic [KLS_W-1:0]  occ_val_k_o [4],
  output logic [KLS_W-1:0]  occ_val_ks_o [4],
  output logic              occ_val_valid_o,
  output logic              busy_o,
  input  logic [KLS_W-1:0]  pri_pos_i,
  input  logic              bwt_params_valid_i,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic              mem_ready_i,
  input  logic [MEM_W-1:0]  mem_rdata_i,
  input  logic              mem_rvalid_i
);

  typedef enum logic [2:0] {
    StIdle,
    StReqK,
    StWaitK,
    StReqKs,
    StWaitKs,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [KLS_W-1:0]  k_q, k_d, ks_q, ks_d;
  logic [KLS_W-1:0]  pri_pos_q, pri_pos_d, pri_cap_q, pri_cap_d;
  logic              mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [KLS_W-1:0]  kcnt_q [4];
  logic [KLS_W-1:0]  kcnt_d [4];
  logic [KLS_W-1:0]  val_k_q [4];
  logic [KLS_W-1:0]  val_k_d [4];
  logic [KLS_W-1:0]  val_ks_q [4];
  logic [KLS_W-1:0]  val_ks_d [4];

  logic [KLS_W-1:0]  eff_k, eff_ks;
  logic [MEM_AW-1:0] word_k, word_ks;
  logic [5:0]        n_k, n_ks;
  logic [KLS_W-1:0]  cnt_k [4];
  logic [KLS_W-1:0]  cnt_ks [4];

  // Checkpoint of symbol sym plus its occurrences in positions 0..n-1 of the word.
  function automatic logic [KLS_W-1:0] occ_count(input logic [MEM_W-1:0] w,
                                                 input logic [1:0] sym,
                                                 input logic [5:0] n);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      if ((7'(i) < {1'b0, n}) && (w[2*i +: 2] == sym)) cnt = cnt + 7'd1;
    end
    return w[128 + KLS_W * int'(sym) +: KLS_W] + KLS_W'(cnt);
  endfunction

  // The '$' row is absent from the stored BWT, so positions past it shift down by one.
  always_comb begin
    eff_k   = (k_q > pri_cap_q) ? k_q - KLS_W'(1) : k_q;
    eff_ks  = (ks_q > pri_cap_q) ? ks_q - KLS_W'(1) : ks_q;
    word_k  = MEM_AW'(eff_k >> 6);
    word_ks = MEM_AW'(eff_ks >> 6);
    n_k     = eff_k[5:0];
    n_ks    = eff_ks[5:0];
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cnt_k[c]  = occ_count(mem_rdata_i, 2'(c), n_k);
      cnt_ks[c] = occ_count(mem_rdata_i, 2'(c), n_ks);
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ks_d       = ks_q;
    pri_cap_d  = pri_cap_q;
    pri_pos_d  = bwt_params_valid_i ? pri_pos_i : pri_pos_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    kcnt_d     = kcnt_q;
    val_k_d    = val_k_q;
    val_ks_d   = val_ks_q;

    case (state_q)
      StIdle: begin
        if (occ_lookup_i) begin
          k_d       = occ_k_i;
          ks_d      = occ_ks_i;
          pri_cap_d = pri_pos_q;
          state_d   = StReqK;
        end
      end
      StReqK: begin
        if (!mem_rd_q) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = word_k;
        end else if (mem_ready_i) begin
          mem_rd_d = 1'b0;
          state_d  = StWaitK;
        end
      end
      StWaitK: begin
        if (mem_rvalid_i) begin
          kcnt_d = cnt_k;
          if (word_ks == word_k) begin
            val_k_d  = cnt_k;
            val_ks_d = cnt_ks;
            state_d  = StDone;
          end else begin
            state_d = StReqKs;
          end
        end
      end
      StReqKs: begin
        if (!mem_rd_q) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = word_ks;
        end else if (mem_ready_i) begin
          mem_rd_d = 1'b0;
          state_d  = StWaitKs;
        end
      end
      StWaitKs: begin
        if (mem_rvalid_i) begin
          val_k_d  = kcnt_q;
          val_ks_d = cnt_ks;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      k_q        <= '0;
      ks_q       <= '0;
      pri_pos_q  <= '0;
      pri_cap_q  <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      for (int c = 0; c < 4; c++) begin
        kcnt_q[c]   <= '0;
        val_k_q[c]  <= '0;
        val_ks_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ks_q       <= ks_d;
      pri_pos_q  <= pri_pos_d;
      pri_cap_q  <= pri_cap_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      kcnt_q     <= kcnt_d;
      val_k_q    <= val_k_d;
      val_ks_q   <= val_ks_d;
    end
  end

  assign occ_val_k_o     = val_k_q;
  assign occ_val_ks_o    = val_ks_q;
  assign occ_val_valid_o = (state_q == StDone);
  assign busy_o          = (state_q != StIdle);
  assign mem_rd_o        = mem_rd_q;
  assign mem_addr_o      = mem_addr_q;

endmodule

// File: doc/occ_lookup.md
OCC_LOOKUP -- requirements
Module: occ_lookup

Interface
REQ-001 Parameter: KLS_W, package BwaMemDefines value, width of k/l/s positions and counts.
REQ-002 Parameter: MEM_AW, 26, BWT word address width.
REQ-003 Parameter: MEM_W, 128+4*KLS_W, BWT word width. Bits [127:0] hold 64 2-bit symbols; position i is at [2i+1:2i], encoded A=0, C=1, G=2, T=3. Bits [128+KLS_W*(c+1)-1 : 128+KLS_W*c] hold the checkpoint count of symbol c.
REQ-004 clk  in  1  single clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 occ_k, occ_ks  in  KLS_W each  query positions k and k+s.
REQ-007 occ_lookup  in  1  one-cycle request strobe.
REQ-008 occ_val_k[0:3], occ_val_ks[0:3]  out  KLS_W each  per-symbol occurrence counts, index 0..3 = A, C, G, T.
REQ-009 occ_val_valid  out  1  one-cycle result strobe.
REQ-010 busy  out  1  lookup in progress.
REQ-011 pri_pos_in  in  KLS_W  BWT primary ('$') position.
REQ-012 bwt_params_valid  in  1  load strobe for pri_pos_in.
REQ-013 mem_addr  out  MEM_AW  word address.
REQ-014 mem_rd  out  1  read request.
REQ-015 mem_ready  in  1  memory accepts a request.
REQ-016 mem_rdata  in  MEM_W  read data.
REQ-017 mem_rvalid  in  1  read data valid.

Function
REQ-018 pri_pos SHALL be registered from pri_pos_in on any cycle with bwt_params_valid=1, including while busy. An in-flight lookup SHALL use the value captured at its start.
REQ-019 Effective position for query p: p' = (p > pri_pos) ? p-1 : p. Word address = p'>>6; n = p'[5:0].
REQ-020 occ(c,p) SHALL equal checkpoint[c] of word p'>>6 plus the count of symbol c among that word's positions 0..n-1. When n=0 the count is the checkpoint alone. Sums SHALL wrap modulo 2^KLS_W.
REQ-021 States: IDLE, REQ_K, WAIT_K, REQ_KS, WAIT_KS, DONE.
REQ-022 IDLE, occ_lookup=1: capture occ_k, occ_ks and pri_pos, then go to REQ_K. In any other state occ_lookup SHALL be ignored.
REQ-023 REQ_K: mem_rd=1 and mem_addr=word(k), held stable until mem_ready=1. On acceptance go to WAIT_K.
REQ-024 Only one read SHALL be outstanding at any time. mem_rvalid SHALL be ignored in IDLE, REQ_K, REQ_KS and DONE.
REQ-025 WAIT_K, on mem_rvalid: compute the k counts from mem_rdata.
  - If word(ks)==word(k), compute the ks counts from the same data and go to DONE; no second read.
  - Otherwise go to REQ_KS.
REQ-026 REQ_KS and WAIT_KS SHALL behave as REQ_K and WAIT_K for word(ks), then go to DONE.
REQ-027 DONE: occ_val_valid=1 for exactly one cycle, then go to IDLE.
REQ-028 occ_val_k and occ_val_ks SHALL be registered and SHALL hold their values from occ_val_valid until the next occ_val_valid.
REQ-029 busy = (state != IDLE).
REQ-030 Latency: with mem_ready=1 and read latency L (request-to-rvalid), occ_val_valid SHALL rise L+3 cycles after the occ_lookup cycle for one read, and 2L+5 cycles after for two reads.
REQ-031 Counting of symbols SHALL be combinational over the 64-symbol word with a count mask of positions < n. The counts SHALL be registered in the rvalid cycle.

Reset
REQ-032 While rst=1, asynchronously:
  - state=IDLE;
  - mem_rd=0, mem_addr=0;
  - occ_val_valid=0, busy=0;
  - all occ_val_k, occ_val_ks and pri_pos = 0.
REQ-033 Reset asserted mid-lookup SHALL abort the lookup with no occ_val_valid. A mem_rvalid arriving after reset release SHALL be ignored.

Verification
Memory contents for all scenarios:
  - Word 0: checkpoints {0,0,0,0}; symbol at position i = i%4.
  - Word 1: checkpoints {16,16,16,16}; all symbols T.
REQ-034 pri_pos=200, k=10, ks=10 -> a single mem_rd at addr 0; k={3,3,2,2}, ks={3,3,2,2}; valid at L+3.
REQ-035 pri_pos=200, k=70, ks=5 -> reads at addr 1 then addr 0; k={16,16,16,22}, ks={2,1,1,1}; valid at 2L+5.
REQ-036 pri_pos=5, k=6, ks=5 -> k uses p'=5, giving {2,1,1,1}; ks={2,1,1,1}; one read.
REQ-037 pri_pos=10, k=0, ks=64 -> ks p'=63 in word 0, giving {16,16,16,15}; k={0,0,0,0}. Then k=65, ks=65 -> p'=64, n=0, giving {16,16,16,16} each.
REQ-038 mem_ready held 0 for 5 cycles -> mem_rd and mem_addr stay stable for those cycles. A second occ_lookup pulse while busy -> ignored.
REQ-039 rst pulsed while in WAIT_KS, then mem_rvalid arrives -> no occ_val_valid; all outputs 0. The next lookup completes correctly.
